untwos_serial: RTL and testbench
================================

Name: untwos_serial

Overview:
- Bit-serial converter from two's-complement to sign-magnitude; the decode direction of the `twos` negation block.
- Sits in the multiplier datapath front end: signed operands are captured once and converted LSB-first, one bit per clock.
- Result is presented as a sign bit plus an unsigned magnitude, ready for the unsigned multiplier core.

Parameters:
- WIDTH, 4, operand width in bits; must be >= 2.

Ports:
- clk  input  1  rising-edge clock (taken from io_in[0] at top level)
- reset  input  1  synchronous, active-low reset; sampled on rising clk
- start  input  1  request conversion of din; sampled only when the block can accept
- din  input  WIDTH  two's-complement operand; sampled on the accepting edge only
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse: sign/mag just updated
- sign  output  1  sign of last converted operand (din[WIDTH-1])
- mag  output  WIDTH  unsigned magnitude of last converted operand
- sout  output  1  serial magnitude bit, LSB first (optional feature)
- sout_valid  output  1  qualifies sout (optional feature)

Behaviour:
- Reset (reset==0 at a rising edge):
  - state=IDLE; busy=0, done=0, sign=0, mag=0, sout=0, sout_valid=0.
  - Internal shift register, bit counter and seen_one flag are cleared.
  - Reset overrides start on the same edge.
  - Reset mid-conversion abandons the conversion; sign/mag go to 0 and no done pulse is produced.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start==1 at edge k: capture din into the shift register; latch sign_int=din[WIDTH-1]; clear counter and seen_one; go to SHIFT.
  - busy=1 from edge k.
- SHIFT, one bit per edge (edges k+1 .. k+WIDTH):
  - b = shift register LSB.
  - If sign_int==0: out=b.
  - If sign_int==1: out = seen_one ? ~b : b; then seen_one |= b.
  - out is shifted into the magnitude accumulator from the MSB side, so the value is complete after WIDTH shifts.
  - The counter increments each edge.
  - At edge k+WIDTH (last bit): go to DONE; load result registers mag and sign; done=1; busy=0.
- DONE (one cycle):
  - done=1; at the next edge done returns to 0.
  - start==1 at that edge is accepted exactly as in IDLE (back-to-back conversions); otherwise go to IDLE.
- Latency: start accepted at edge k -> done high for the cycle after edge k+WIDTH; throughput one operand per WIDTH+1 cycles.
- start while busy==1 is ignored and din is not resampled. The in-flight conversion is unaffected.
- sign/mag hold their value from the last done until the next done or reset. They never show partial results.
- Arithmetic rules:
  - mag is unsigned, width WIDTH.
  - Most negative input -2^(WIDTH-1) converts to sign=1, mag=2^(WIDTH-1) (MSB set, other bits 0). No overflow flag.
  - din=0 converts to sign=0, mag=0. There is no negative zero.

Optional Feature:
- Macro: UNTWOS_SERIAL_SOUT_EN.
- Defined:
  - sout carries `out` for each SHIFT-edge bit, registered, so it is valid in the cycle following the edge that processed it.
  - sout_valid=1 for exactly WIDTH consecutive cycles per conversion, the last of which coincides with done.
  - Lets the serial multiplier consume magnitude bits without waiting for done.
- Undefined: sout and sout_valid ports still exist but are tied to 0 (no floating pins at top level); no serial registers are generated.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles, release; no start -> busy=0, done=0, sign=0, mag=4'b0000 indefinitely.
- Positive operand: WIDTH=4, din=4'b0110, start pulse at edge k -> busy=1 for edges k..k+3, done pulse after edge k+4, sign=0, mag=4'b0110; with SOUT_EN, sout sequence 0,1,1,0.
- Negative operand: din=4'b1010 (-6) -> sign=1, mag=4'b0110; with SOUT_EN, sout sequence 0,1,1,0 (LSB first), sout_valid high 4 cycles.
- Boundaries:
  - din=4'b1000 -> sign=1, mag=4'b1000.
  - din=4'b1111 -> sign=1, mag=4'b0001.
  - din=4'b0000 -> sign=0, mag=4'b0000.
- Ignored start and back-to-back:
  - Second start with din=4'b0011 two cycles into a conversion of 4'b1110 -> result sign=1, mag=4'b0010, one done only.
  - start held high in DONE with din=4'b0101 -> next conversion accepted immediately, sign=0, mag=4'b0101 one period later.
- Reset mid-operation: assert reset=0 at edge k+2 of a conversion of 4'b1001 -> no done, sign=0, mag=0, busy=0. A new start after release converts normally (sign=1, mag=4'b0111).

Source files
------------

// File: rtl/untwos_serial_if.sv
// untwos_serial_if: start/operand request and sign-magnitude result bundle for untwos_serial.
interface untwos_serial_if #(parameter int WIDTH = 4);
    logic             start;
    logic [WIDTH-1:0] din;
    logic             busy;
    logic             done;
    logic             sign;
    logic [WIDTH-1:0] mag;
    logic             sout;
    logic             sout_valid;
    modport master (output start, din, input busy, done, sign, mag, sout, sout_valid);
    modport slave  (input start, din, output busy, done, sign, mag, sout, sout_valid);
endinterface

// File: rtl/untwos_serial.sv
// untwos_serial: bit-serial two's-complement to sign-magnitude converter, LSB first.
// Define UNTWOS_SERIAL_SOUT_EN to drive the registered serial magnitude on sout/sout_valid.
module untwos_serial #(parameter int WIDTH = 4) (
    input  logic           clk,
    input  logic           reset,
    untwos_serial_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_sh, r_acc, r_mag;
    logic [CW-1:0]    r_cnt;
    logic             r_sign_int, r_seen, r_sign;
    logic             w_accept, w_shift, w_last, w_b, w_out;
    assign w_b    = r_sh[0];
    // Negation LSB-first: copy bits up to and including the first 1, invert the rest.
    assign w_out  = (r_sign_int & r_seen) ? ~w_b : w_b;
    assign w_last = r_cnt == CW'(WIDTH - 1);
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_shift  = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                w_accept = bus.start;
                w_next   = bus.start ? SHIFT : IDLE;
            end
            SHIFT: begin
                w_shift = 1'b1;
                w_next  = w_last ? DONE : SHIFT;
            end
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) r_state <= IDLE;
        else r_state <= w_next;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sh       <= '0;
            r_acc      <= '0;
            r_mag      <= '0;
            r_cnt      <= '0;
            r_sign_int <= 1'b0;
            r_seen     <= 1'b0;
            r_sign     <= 1'b0;
        end else if (w_accept) begin
            r_sh       <= bus.din;
            r_sign_int <= bus.din[WIDTH-1];
            r_cnt      <= '0;
            r_seen     <= 1'b0;
        end else if (w_shift) begin
            r_sh   <= r_sh >> 1;
            r_acc  <= {w_out, r_acc[WIDTH-1:1]};
            r_cnt  <= r_cnt + 1'b1;
            r_seen <= r_seen | w_b;
            if (w_last) begin
                r_mag  <= {w_out, r_acc[WIDTH-1:1]};
                r_sign <= r_sign_int;
            end
        end
    end
    assign bus.busy = r_state == SHIFT;
    assign bus.done = r_state == DONE;
    assign bus.sign = r_sign;
    assign bus.mag  = r_mag;
`ifdef UNTWOS_SERIAL_SOUT_EN
    logic r_sout, r_sout_valid;
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sout       <= 1'b0;
            r_sout_valid <= 1'b0;
        end else begin
            r_sout       <= w_shift & w_out;
            r_sout_valid <= w_shift;
        end
    end
    assign bus.sout       = r_sout;
    assign bus.sout_valid = r_sout_valid;
`else
    assign bus.sout       = 1'b0;
    assign bus.sout_valid = 1'b0;
`endif
endmodule

// File: tb/tb_untwos_serial.sv
// tb_untwos_serial: directed vectors against an arithmetic sign-magnitude model, checked every cycle.
module tb_untwos_serial;
    localparam int W = 4;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic chk_en = 1'b0;
    int   checks = 0;
    int   errors = 0;
    untwos_serial_if #(.WIDTH(W)) bus ();
    untwos_serial #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a conversion occupies W cycles after acceptance, then publishes |din| with its sign.
    int         m_rem = 0;
    logic       m_done = 1'b0, m_sign = 1'b0, m_sout = 1'b0, m_sv = 1'b0;
    logic       p_sign = 1'b0;
    logic [W-1:0] m_mag = '0, p_mag = '0;
    always @(posedge clk) begin
        if (!reset) begin
            m_rem  <= 0;
            m_done <= 1'b0;
            m_sign <= 1'b0;
            m_mag  <= '0;
            m_sout <= 1'b0;
            m_sv   <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_rem > 0) begin
                if (m_rem == 1) begin
                    m_done <= 1'b1;
                    m_sign <= p_sign;
                    m_mag  <= p_mag;
                end
                m_sout <= p_mag[W-m_rem];
                m_sv   <= 1'b1;
                m_rem  <= m_rem - 1;
            end else begin
                m_sout <= 1'b0;
                m_sv   <= 1'b0;
                if (bus.start) begin
                    m_rem  <= W;
                    p_sign <= bus.din[W-1];
                    p_mag  <= bus.din[W-1] ? W'(-bus.din) : bus.din;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", bus.busy, m_rem > 0);
            chk("done", bus.done, m_done);
            chk("sign", bus.sign, m_sign);
            chk("mag", bus.mag, m_mag);
`ifdef UNTWOS_SERIAL_SOUT_EN
            chk("sout_valid", bus.sout_valid, m_sv);
            if (m_sv) chk("sout", bus.sout, m_sout);
`else
            chk("sout_tied", bus.sout, 0);
            chk("sout_valid_tied", bus.sout_valid, 0);
`endif
        end
    end

    task automatic wait_done(output int n);
        n = 0;
        while (!bus.done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", bus.done, 1);
    endtask

    task automatic convert(input logic [W-1:0] d, input logic es, input logic [W-1:0] em);
        int n;
        @(negedge clk);
        bus.start = 1'b1;
        bus.din   = d;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(n);
        chk("latency", n, W);
        chk("lit_sign", bus.sign, es);
        chk("lit_mag", bus.mag, em);
    endtask

    initial begin
        int n, dones;
        bus.start = 1'b0;
        bus.din   = '0;
        repeat (2) @(negedge clk);
        reset  = 1'b1;
        chk_en = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_busy", bus.busy, 0);
        chk("idle_done", bus.done, 0);
        chk("idle_mag", bus.mag, 0);
        convert(4'b0110, 1'b0, 4'b0110);
        convert(4'b1010, 1'b1, 4'b0110);
        convert(4'b1000, 1'b1, 4'b1000);
        convert(4'b1111, 1'b1, 4'b0001);
        convert(4'b0000, 1'b0, 4'b0000);
        convert(4'b0111, 1'b0, 4'b0111);
        convert(4'b1001, 1'b1, 4'b0111);
        // Start arriving mid-conversion must be ignored.
        @(negedge clk);
        bus.start = 1'b1;
        bus.din   = 4'b1110;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.din   = 4'b0011;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(n);
        chk("ign_sign", bus.sign, 1);
        chk("ign_mag", bus.mag, 4'b0010);
        // Back-to-back: start presented during DONE.
        bus.start = 1'b1;
        bus.din   = 4'b0101;
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b_busy", bus.busy, 1);
        wait_done(n);
        chk("b2b_latency", n, W);
        chk("b2b_sign", bus.sign, 0);
        chk("b2b_mag", bus.mag, 4'b0101);
        dones = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        chk("no_extra_done", dones, 0);
        // Reset sampled at edge k+2 abandons the conversion.
        bus.start = 1'b1;
        bus.din   = 4'b1001;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_sign", bus.sign, 0);
        chk("rst_mag", bus.mag, 0);
        reset = 1'b1;
        dones = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        chk("rst_no_done", dones, 0);
        convert(4'b1001, 1'b1, 4'b0111);
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
